// File: rtl/pe_accumulator.sv
// Sums KERNEL_SIZE PE products per window, rescales/rounds/saturates the total and queues it in a FIFO.
// Latency: last product to out_valid is 2 edges. Input is never stalled; a result that finds the FIFO full is dropped and flagged.
module pe_accumulator #(
  parameter int PROD_WIDTH  = 16,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_WIDTH   = 20,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT       = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PROD_WIDTH-1:0] acc_in,
  input  logic                  acc_in_valid,
  input  logic                  acc_clear,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  busy
);
  localparam int CW = $clog2(KERNEL_SIZE);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [SW-1:0] RND  = (SW'(1) << SHIFT) >> 1;
  localparam logic [SW-1:0] MAXV = {{(SW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic [CW-1:0]        count_q, count_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d, sum_plus;
  logic                 scl_vld_q, scl_vld_d;
  logic [ACC_WIDTH-1:0] scl_sum_q, scl_sum_d;
  logic                 res_vld_q;
  logic [OUT_WIDTH-1:0] res_q, res_d;
  logic [SW-1:0]        rnd_sum, shifted;

  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]          occ_q, occ_d, remain;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 ovf_q, ovf_d;
  logic                 pop, full, push_ok;

  assign sum_plus = sum_q + ACC_WIDTH'(acc_in);

  // Clear wins over a coincident product; the last product hands the total to the scale stage.
  always_comb begin
    count_d   = count_q;
    sum_d     = sum_q;
    scl_vld_d = 1'b0;
    scl_sum_d = scl_sum_q;
    if (acc_clear) begin
      count_d = '0;
      sum_d   = '0;
    end else if (acc_in_valid) begin
      if (count_q == CW'(KERNEL_SIZE - 1)) begin
        scl_vld_d = 1'b1;
        scl_sum_d = sum_plus;
        count_d   = '0;
        sum_d     = '0;
      end else begin
        count_d = count_q + CW'(1);
        sum_d   = sum_plus;
      end
    end
  end

  assign rnd_sum = {1'b0, scl_sum_q} + RND;
  assign shifted = rnd_sum >> SHIFT;
  assign res_d   = (shifted > MAXV) ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];

  assign pop     = out_valid & out_ready;
  assign full    = (occ_q == (PW+1)'(FIFO_DEPTH));
  assign push_ok = res_vld_q & (~full | pop);
  assign occ_d   = occ_q + (PW+1)'(push_ok) - (PW+1)'(pop);
  assign rd_d    = rd_q + PW'(pop);
  assign wr_d    = wr_q + PW'(push_ok);
  assign remain  = occ_q - (PW+1)'(pop);
  assign ovf_d   = ovf_q | (res_vld_q & full & ~pop);

  // Registered head: the incoming result becomes head only when no older entry survives this edge.
  always_comb begin
    data_d = '0;
    if (occ_d != '0) begin
      if (remain == '0) data_d = res_q;
      else              data_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      sum_q     <= '0;
      scl_vld_q <= 1'b0;
      scl_sum_q <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      occ_q     <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      sum_q     <= sum_d;
      scl_vld_q <= scl_vld_d;
      scl_sum_q <= scl_sum_d;
      res_vld_q <= scl_vld_q;
      if (scl_vld_q) res_q <= res_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      occ_q     <= occ_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= res_q;
  end

  assign out_data  = data_q;
  assign out_valid = (occ_q != '0);
  assign overflow  = ovf_q;
  assign busy      = (count_q != '0) | scl_vld_q | res_vld_q;
endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator: directed windows plus randomized traffic against a queue-based window/FIFO model.
module tb_pe_accumulator;
  localparam int K     = 9;
  localparam int SH    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] acc_in;
  logic        acc_in_valid, acc_clear, out_ready;
  logic [7:0]  out_data;
  logic        out_valid, overflow, busy;
  logic        acc_in_valid0, rdy0;
  logic [7:0]  out_data0;
  logic        out_valid0, overflow0, busy0;

  always #5 clk = ~clk;

  pe_accumulator u_dut (
    .clk(clk), .rst(rst), .acc_in(acc_in), .acc_in_valid(acc_in_valid), .acc_clear(acc_clear),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .busy(busy));

  pe_accumulator #(.SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .acc_in(acc_in), .acc_in_valid(acc_in_valid0), .acc_clear(acc_clear),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(rdy0), .overflow(overflow0), .busy(busy0));

  int checks = 0;
  int passes = 0;
  int vcnt   = 0;
  int got[$];
  int got0[$];

  // Reference model: window sums, a list of results waiting to land, and the FIFO contents.
  longint m_sum;
  int     m_cnt;
  int     m_fifo[$];
  int     pend_val[$];
  longint pend_due[$];
  bit     m_ovf;
  longint cyc;

  function automatic int px(longint s, int sh);
    longint r;
    r = (s + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0)) >> sh;
    return (r > 255) ? 255 : int'(r);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_got(input string name, input int idx, input int exp);
    if (idx < got.size()) chk(name, got[idx], exp);
    else chk(name, -1, exp);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum = 0; m_cnt = 0; m_ovf = 0; cyc = 0;
      m_fifo.delete(); pend_val.delete(); pend_due.delete();
    end else begin
      cyc++;
      if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(pend_val[0]);
        else m_ovf = 1;
        void'(pend_val.pop_front());
        void'(pend_due.pop_front());
      end
      if (acc_clear) begin
        m_sum = 0; m_cnt = 0;
      end else if (acc_in_valid) begin
        m_sum += acc_in;
        m_cnt++;
        if (m_cnt == K) begin
          pend_val.push_back(px(m_sum, SH));
          pend_due.push_back(cyc + 2);
          m_sum = 0; m_cnt = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(int'(out_data));
    if (!rst && out_valid0 && rdy0) got0.push_back(int'(out_data0));
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, m_fifo.size() != 0);
      chk("out_data", out_data, (m_fifo.size() != 0) ? m_fifo[0] : 0);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, (m_cnt != 0) || (pend_val.size() != 0));
      if (out_valid) vcnt++;
    end
  end

  task automatic cyc1(input bit v, input int d, input bit c);
    acc_in_valid = v; acc_in = 16'(d); acc_clear = c;
    @(posedge clk); #1;
    acc_in_valid = 0; acc_clear = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic window(input int d);
    repeat (K) cyc1(1, d, 0);
  endtask

  task automatic pulse_reset();
    rst = 1; #2; rst = 0;
    got.delete(); vcnt = 0;
  endtask

  initial begin
    acc_in = 0; acc_in_valid = 0; acc_clear = 0; out_ready = 1;
    acc_in_valid0 = 0; rdy0 = 1;
    rst = 0; #1 rst = 1; #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 0;

    // Continuous window of 256s
    got.delete(); vcnt = 0;
    window(256); idle(5);
    chk("t1_count", got.size(), 1);
    chk_got("t1_val", 0, 9);
    chk("t1_valid_cycles", vcnt, 1);

    // Rounding boundary
    got.delete();
    repeat (8) cyc1(1, 0, 0); cyc1(1, 128, 0); idle(4);
    repeat (8) cyc1(1, 0, 0); cyc1(1, 127, 0); idle(4);
    chk_got("round_128", 0, 1);
    chk_got("round_127", 1, 0);

    // Saturation
    got.delete();
    window(65025); idle(4);
    chk_got("sat_val", 0, 255);
    chk("sat_overflow", overflow, 0);

    // Backpressure: five windows into a four-entry FIFO
    got.delete(); out_ready = 0;
    for (int i = 1; i <= 5; i++) window(256 * i);
    idle(4);
    chk("bp_overflow", overflow, 1);
    chk("bp_valid_held", out_valid, 1);
    out_ready = 1; idle(6);
    chk("bp_count", got.size(), 4);
    chk_got("bp_0", 0, 9);
    chk_got("bp_1", 1, 18);
    chk_got("bp_2", 2, 27);
    chk_got("bp_3", 3, 36);
    chk("bp_drained", out_valid, 0);
    pulse_reset();

    // Gapped input
    for (int i = 0; i < K; i++) begin cyc1(1, 256, 0); cyc1(0, 0, 0); end
    idle(4);
    chk("gap_count", got.size(), 1);
    chk_got("gap_val", 0, 9);

    // Clear coincident with a product
    got.delete();
    repeat (4) cyc1(1, 256, 0);
    cyc1(1, 256, 1);
    window(256); idle(4);
    chk("clr_count", got.size(), 1);
    chk_got("clr_val", 0, 9);

    // SHIFT=0 build
    got0.delete();
    repeat (K) begin acc_in_valid0 = 1; acc_in = 16'd20; @(posedge clk); #1; end
    acc_in_valid0 = 0; idle(4);
    chk("s0_count", got0.size(), 1);
    chk("s0_val", (got0.size() > 0) ? got0[0] : -1, 180);

    // Async reset with FIFO data and a partial window
    out_ready = 0; got.delete();
    window(256); idle(3);
    repeat (4) cyc1(1, 256, 0);
    chk("ar_pre_valid", out_valid, 1);
    #1 rst = 1; #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_overflow", overflow, 0);
    #1 rst = 0;
    got.delete(); out_ready = 1;
    window(256); idle(5);
    chk("ar_count", got.size(), 1);
    chk_got("ar_val", 0, 9);

    // Randomized traffic
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cyc1($urandom_range(0, 3) != 0, int'($urandom & (32'hFFFF >> $urandom_range(0, 12))),
           $urandom_range(0, 60) == 0);
    end
    out_ready = 1; idle(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pe_accumulator.md
Name: pe_accumulator

Overview:
- Downstream consumer of one PE column: takes the product stream (`pe_output` with `pe_done`) and sums KERNEL_SIZE consecutive valid products into one convolution window result.
- Each window total is rescaled, rounded and saturated to pixel width, then queued in a small output FIFO.
- The FIFO is read over a valid/ready handshake by the next layer or writeback stage.
- The PE cannot be stalled, so input is never back-pressured; loss is flagged instead.

Parameters:
- PROD_WIDTH, 16, width of incoming product (DATA_WIDTH+WEIGHT_WIDTH).
- KERNEL_SIZE, 9, products per window (≥2).
- ACC_WIDTH, 20, accumulator width; must be ≥ PROD_WIDTH+ceil(log2(KERNEL_SIZE)).
- OUT_WIDTH, 8, output pixel width.
- SHIFT, 8, right-shift rescale applied to window sum (0 allowed).
- FIFO_DEPTH, 4, output FIFO entries (power of two).

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- acc_in, input, PROD_WIDTH, unsigned product from PE (`pe_output`).
- acc_in_valid, input, 1, product valid (`pe_done`).
- acc_clear, input, 1, synchronous abort of the partial window.
- out_data, output, OUT_WIDTH, FIFO head value.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, consumer accepts head.
- overflow, output, 1, sticky: a window result was dropped on full FIFO.
- busy, output, 1, partial window in progress (count≠0) or scale stage occupied.

Behaviour:
- Reset (async, rst=1) clears:
  - count=0, sum=0, scale stage empty;
  - FIFO pointers and occupancy=0;
  - out_valid=0, out_data=0, overflow=0, busy=0.
- Release is synchronous to clk; the first product can be taken on the first edge with rst=0.
- Accumulate stage, every edge with acc_in_valid=1 and acc_clear=0:
  - Not the last product (count<KERNEL_SIZE-1): sum<=sum+acc_in, count<=count+1.
  - Last product (count==KERNEL_SIZE-1): final=sum+acc_in is loaded into the scale stage register (valid set), and sum<=0, count<=0 in the same edge. Back-to-back windows incur no bubble.
- Cycles with acc_in_valid=0 hold count and sum; gaps of any length are legal.
- acc_clear=1 sets count<=0 and sum<=0. It has priority over a simultaneous valid product, which is discarded. It does not affect the scale stage, FIFO or overflow.
- Scale stage: one register stage. Next edge computes r=(final + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, i.e. round-half-up. If r>2^OUT_WIDTH-1 the result is 2^OUT_WIDTH-1 (saturate), else r. The result is pushed into the FIFO.
- Scale stage widths: intermediate math uses ACC_WIDTH+1 bits; no wrap allowed.
- Latency: last product sampled at edge t → out_valid=1 and out_data=result after edge t+2 (FIFO previously empty).
- FIFO:
  - out_data always shows the head entry, registered; it is 0 when empty.
  - out_valid = occupancy≠0.
  - Pop when out_valid and out_ready on an edge.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO push when full:
  - Without a same-edge pop: the result is dropped, overflow<=1 (sticky until rst), and FIFO contents are unchanged.
  - With a same-edge pop: the push succeeds and occupancy stays FIFO_DEPTH.
- Push and pop on the same edge when non-empty: occupancy unchanged, order preserved.
- out_ready is ignored while out_valid=0.
- busy is combinational from count≠0 or scale-valid.
- Reset asserted mid-window or with FIFO data discards everything; there is no partial output after release.

Test Plan:
- Nine products of 256, valid continuous, out_ready=1 → out_data=9 (2304+128>>8) with out_valid high exactly one cycle, 2 cycles after the 9th product.
- Rounding: eight 0s plus one 128 → out_data=1; repeat with one 127 → out_data=0; SHIFT=0 build with nine 20s → 180.
- Saturation: nine products of 65025 → sum 585225 → out_data=255, overflow stays 0.
- Backpressure: out_ready=0, five back-to-back windows with per-window constants 256,512,768,1024,1280 → four entries held (9,18,27,36), fifth dropped, overflow=1. Then out_ready=1 drains 9,18,27,36 in order; out_valid falls after the 4th pop.
- Gaps and clear: nine products with acc_in_valid toggling 1/0 → same result as continuous. Four products, acc_clear pulsed coincident with a 5th valid product, then nine 256s → single output 9.
- Async reset mid-window: four products, rst pulsed between edges → all outputs 0 immediately. After release, nine 256s → exactly one output 9.
